cmem_arbiter: RTL
=================

Name: cmem_arbiter

Overview:
- Round-robin arbiter that shares the single-port layer memory (L0/L1, selected by csel) between NREQ requesters, e.g. the conv writer, the maxpool reader and the maxpool writer.
- Issues one memory command per cycle.
- Drives registered cwr/crd/caddr/cdata/csel toward the memory.
- Routes read data back to the requester that issued the read, with a fixed latency.

Parameters:
- NREQ, 3, number of requesters (2..4); requester index i uses bit i / slice i of every flattened bus.
- AW, 12, memory address width.
- DW, 20, memory data width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  request, one bit per requester; held until granted.
- req_we  input  NREQ  1 = write, 0 = read.
- req_sel  input  3*NREQ  memory select per requester (drives csel).
- req_addr  input  AW*NREQ  address per requester.
- req_wdata  input  DW*NREQ  write data per requester.
- req_lock  input  NREQ  keep the grant after this access (burst; optional feature only).
- gnt  output  NREQ  combinational one-hot grant; the request is consumed at this clock edge.
- rvalid  output  NREQ  registered, one-hot; read data valid for requester i.
- rdata  output  DW  read data, shared by all requesters; qualified by rvalid.
- cwr  output  1  memory write strobe.
- crd  output  1  memory read strobe.
- caddr_wr  output  AW  memory write address.
- caddr_rd  output  AW  memory read address.
- cdata_wr  output  DW  memory write data.
- cdata_rd  input  DW  memory read data, valid 1 cycle after crd.
- csel  output  3  memory select.

Behaviour:
- Reset (reset=0, async):
  - cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel, rvalid, rdata = 0.
  - rr_ptr = 0; read pipeline cleared; state = IDLE.
  - Reads in flight at reset are discarded; no rvalid is ever produced for them.
- Grant (combinational, cycle T):
  - Search req starting at rr_ptr, upward with wrap-around; the first set bit gets gnt.
  - gnt = 0 when req = 0.
  - gnt is never asserted for a requester whose req bit is 0.
- Pointer update at the edge ending cycle T:
  - rr_ptr = granted index + 1, modulo NREQ.
  - Unchanged when there is no grant.
- Command issue at T+1 (registered from the granted slice):
  - Write: cwr=1, caddr_wr=addr, cdata_wr=wdata, csel=sel, crd=0.
  - Read: crd=1, caddr_rd=addr, csel=sel, cwr=0.
  - No grant: cwr=0, crd=0; address, data and csel hold their last values.
- Read return:
  - Requester id travels a 2-stage pipeline with the read.
  - At T+2, rdata = cdata_rd and rvalid[id] = 1 for exactly one cycle.
  - Total read latency from grant to rvalid: 2 cycles.
  - Back-to-back reads give one rvalid per cycle, in issue order.
- Throughput: one grant per cycle. With all NREQ requesting continuously, each requester is granted once every NREQ cycles.
- State machine:
  - IDLE: no grant this cycle.
  - ACTIVE: a grant was issued this cycle.
  - LOCKED: only with the optional feature enabled.
  - IDLE -> ACTIVE when req != 0.
  - ACTIVE -> IDLE when req = 0.
- Simultaneous events:
  - A requester may re-assert req in the cycle after its grant; it is arbitrated normally, behind the other active requesters.
  - A write and a read return in the same cycle are independent: cwr=1 and rvalid=1 may coincide.

Optional Feature:
- Macro: CMEM_ARB_LOCK_EN.
- Enabled:
  - If the granted requester has req_lock=1, the arbiter enters LOCKED and stores the owner index.
  - While LOCKED, only the owner can be granted; other requests wait.
  - rr_ptr is frozen while LOCKED.
  - Leave LOCKED (to ACTIVE or IDLE) after the owner's first granted access with req_lock=0.
  - Also leave LOCKED if the owner drops req; rr_ptr then advances past the owner.
  - Intended use: a maxpool 2x2 window of 4 reads without interleaving.
- Disabled: the req_lock input is ignored and the LOCKED state does not exist.

Test Plan:
- Reset mid-read: read granted at cycle 5, reset pulled low at cycle 6 -> no rvalid at cycle 7; all outputs 0; the next grant goes to requester 0.
- Single write: req=3'b001, req_we[0]=1, addr 0x041, wdata 0x00ABC, sel 1 -> gnt=001 at T; at T+1 cwr=1, caddr_wr=0x041, cdata_wr=0x00ABC, csel=1.
- Single read: req[1], addr 0x3FF, memory returns 0x12345 -> rvalid=010 and rdata=0x12345 exactly at T+2; crd=1 only at T+1.
- Round-robin: req=3'b111 held for 6 cycles -> gnt sequence 001,010,100,001,010,100; no requester waits more than 2 cycles.
- Lock (CMEM_ARB_LOCK_EN defined): requester 2 issues 4 reads, req_lock=1 on the first 3, while req[0] is held high -> four consecutive gnt=100, then gnt=001. Without the macro, grants interleave 100,001,100,001.
- Back-to-back mixed traffic: write to 0x010 then read from 0x010 by a different requester -> cwr then crd on consecutive cycles; rdata equals the written value at read T+2.

Source files
------------

// File: rtl/cmem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmem_arbiter_if                                                          |
// | Requester and layer-memory bus between the arbiter and its neighbours.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface cmem_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 12,
  parameter int DW   = 20
) ();
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [3*NREQ-1:0]  req_sel;
  logic [AW*NREQ-1:0] req_addr;
  logic [DW*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               cwr;
  logic               crd;
  logic [AW-1:0]      caddr_wr;
  logic [AW-1:0]      caddr_rd;
  logic [DW-1:0]      cdata_wr;
  logic [DW-1:0]      cdata_rd;
  logic [2:0]         csel;

  modport slave (
    input  req, req_we, req_sel, req_addr, req_wdata, req_lock, cdata_rd,
    output gnt, rvalid, rdata, cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel
  );

  modport master (
    output req, req_we, req_sel, req_addr, req_wdata, req_lock, cdata_rd,
    input  gnt, rvalid, rdata, cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel
  );
endinterface
`default_nettype wire

// File: rtl/cmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmem_arbiter                                                             |
// | Round-robin arbiter sharing the single-port layer memory among NREQ      |
// | requesters; reads return on rvalid/rdata two cycles after the grant.     |
// | Optional burst lock: define CMEM_ARB_LOCK_EN.                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cmem_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 12,
  parameter int DW   = 20
) (
  input  logic          clk,
  input  logic          reset,
  cmem_arbiter_if.slave bus
);

  localparam int c_IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1
`ifdef CMEM_ARB_LOCK_EN
    ,S_LOCKED = 2'd2
`endif
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_IDX_W-1:0]   r_rr_ptr;
  logic [c_IDX_W-1:0]   w_rr_ptr_nxt;
  logic [NREQ-1:0]      w_elig;
  logic [NREQ-1:0]      w_gnt;
  logic [c_IDX_W-1:0]   w_gnt_idx;
  logic                 w_gnt_vld;
  logic                 w_we;
  logic [2:0]           w_sel;
  logic [AW-1:0]        w_addr;
  logic [DW-1:0]        w_wdata;

  logic                 r_cwr;
  logic                 r_crd;
  logic [AW-1:0]        r_caddr_wr;
  logic [AW-1:0]        r_caddr_rd;
  logic [DW-1:0]        r_cdata_wr;
  logic [2:0]           r_csel;
  logic                 r_rd_v1;
  logic [c_IDX_W-1:0]   r_rd_id1;
  logic [NREQ-1:0]      r_rvalid;

  function automatic logic [c_IDX_W-1:0] f_next_idx(input logic [c_IDX_W-1:0] i);
    return (i == c_IDX_W'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

`ifdef CMEM_ARB_LOCK_EN
  logic [c_IDX_W-1:0]   r_owner;
  logic [NREQ-1:0]      w_owner_mask;

  always_comb begin
    w_owner_mask          = '0;
    w_owner_mask[r_owner] = 1'b1;
    w_elig = (r_state == S_LOCKED) ? (bus.req & w_owner_mask) : bus.req;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_owner <= '0;
    else if (w_gnt_vld) r_owner <= w_gnt_idx;
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^{bus.req_lock, r_state};
  assign w_elig        = bus.req;
`endif

  // First eligible requester at or after the pointer, with wrap-around.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(r_rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_gnt_vld && w_elig[j]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = c_IDX_W'(j);
      end
    end
    w_gnt = '0;
    if (w_gnt_vld) w_gnt[w_gnt_idx] = 1'b1;
  end

  assign w_we    = bus.req_we[w_gnt_idx];
  assign w_sel   = bus.req_sel[int'(w_gnt_idx)*3 +: 3];
  assign w_addr  = bus.req_addr[int'(w_gnt_idx)*AW +: AW];
  assign w_wdata = bus.req_wdata[int'(w_gnt_idx)*DW +: DW];

  always_comb begin
    w_state_nxt  = S_IDLE;
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_gnt_vld) begin
      w_rr_ptr_nxt = f_next_idx(w_gnt_idx);
      w_state_nxt  = S_ACTIVE;
`ifdef CMEM_ARB_LOCK_EN
      if (bus.req_lock[w_gnt_idx]) w_state_nxt = S_LOCKED;
`endif
    end
`ifdef CMEM_ARB_LOCK_EN
    // Owner released its request mid-burst: skip past it.
    else if (r_state == S_LOCKED) begin
      w_rr_ptr_nxt = f_next_idx(r_owner);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cwr      <= 1'b0;
      r_crd      <= 1'b0;
      r_caddr_wr <= '0;
      r_caddr_rd <= '0;
      r_cdata_wr <= '0;
      r_csel     <= '0;
      r_rd_v1    <= 1'b0;
      r_rd_id1   <= '0;
      r_rvalid   <= '0;
    end else begin
      r_cwr <= 1'b0;
      r_crd <= 1'b0;
      if (w_gnt_vld) begin
        r_csel <= w_sel;
        if (w_we) begin
          r_cwr      <= 1'b1;
          r_caddr_wr <= w_addr;
          r_cdata_wr <= w_wdata;
        end else begin
          r_crd      <= 1'b1;
          r_caddr_rd <= w_addr;
        end
      end
      // Requester id follows the read so the return can be steered.
      r_rd_v1  <= w_gnt_vld & ~w_we;
      r_rd_id1 <= w_gnt_idx;
      r_rvalid <= '0;
      if (r_rd_v1) r_rvalid[r_rd_id1] <= 1'b1;
    end
  end

  assign bus.gnt      = w_gnt;
  assign bus.cwr      = r_cwr;
  assign bus.crd      = r_crd;
  assign bus.caddr_wr = r_caddr_wr;
  assign bus.caddr_rd = r_caddr_rd;
  assign bus.cdata_wr = r_cdata_wr;
  assign bus.csel     = r_csel;
  assign bus.rvalid   = r_rvalid;
  assign bus.rdata    = (|r_rvalid) ? bus.cdata_rd : '0;

endmodule
`default_nettype wire
